// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch/PC sequencer: memory-wait stalls, load-use bubbles, branch squash, halt.
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ihit,
    input  logic             i_dhit,
    input  logic             i_mem_dreq,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_dREN,
    input  logic             i_br_taken,
    input  logic             i_mem_halt,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_en,
    output logic             o_idex_flush,
    output logic             o_exmem_en,
    output logic             o_exmem_flush,
    output logic             o_memwb_en,
    output logic             o_imem_ren,
    output logic             o_dmem_req_en,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count
);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;

    state_t r_state;
    logic   r_ihit_seen;
    logic   r_dhit_seen;

    logic w_ifetch_ok;
    logic w_dmem_ok;
    logic w_advance;
    logic w_load_use;
    logic w_not_halt;

    assign w_not_halt  = (r_state != S_HALT);
    assign w_ifetch_ok = i_ihit | r_ihit_seen;
    assign w_dmem_ok   = !i_mem_dreq | i_dhit | r_dhit_seen;
    assign w_advance   = w_ifetch_ok & w_dmem_ok & w_not_halt;
    assign w_load_use  = i_ex_dREN && (i_ex_rd != '0) &&
                         ((i_ex_rd == i_id_rs) || (i_ex_rd == i_id_rt));

    // Seen bits remember a half-finished I/D access so it is not re-requested while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_RUN;
            r_ihit_seen <= 1'b0;
            r_dhit_seen <= 1'b0;
        end else if (w_not_halt) begin
            if (w_advance) begin
                r_ihit_seen <= 1'b0;
                r_dhit_seen <= 1'b0;
                r_state     <= i_mem_halt ? S_HALT : S_RUN;
            end else begin
                r_state <= S_WAIT;
                if (i_ihit) r_ihit_seen <= 1'b1;
                if (i_dhit) r_dhit_seen <= 1'b1;
            end
        end
    end

    always_comb begin
        o_pc_en       = 1'b0;
        o_ifid_en     = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_en     = 1'b0;
        o_idex_flush  = 1'b0;
        o_exmem_en    = 1'b0;
        o_exmem_flush = 1'b0;
        o_memwb_en    = 1'b0;
        o_imem_ren    = 1'b0;
        o_dmem_req_en = 1'b0;
        o_halted      = 1'b0;
        if (!i_rst) begin
            o_halted      = !w_not_halt;
            o_imem_ren    = !r_ihit_seen & w_not_halt;
            o_dmem_req_en = i_mem_dreq & !r_dhit_seen & w_not_halt;
            // Priority: halt drains only MEM/WB, then branch squash, then load-use bubble.
            if (w_advance) begin
                if (i_mem_halt) begin
                    o_memwb_en = 1'b1;
                end else if (i_br_taken) begin
                    o_pc_en       = 1'b1;
                    o_memwb_en    = 1'b1;
                    o_ifid_flush  = 1'b1;
                    o_idex_flush  = 1'b1;
                    o_exmem_flush = 1'b1;
                end else if (w_load_use) begin
                    o_idex_flush = 1'b1;
                    o_exmem_en   = 1'b1;
                    o_memwb_en   = 1'b1;
                end else begin
                    o_pc_en    = 1'b1;
                    o_ifid_en  = 1'b1;
                    o_idex_en  = 1'b1;
                    o_exmem_en = 1'b1;
                    o_memwb_en = 1'b1;
                end
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_not_halt && !w_advance && (r_stall_cycles != {CNT_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_advance && i_br_taken && (r_flush_count != {CNT_W{1'b1}}))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;
`else
    assign o_stall_cycles = '0;
    assign o_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; counter checks adapt to PIPE_PERF_CNT_EN.
// Control vector order: {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en}.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [7:0] C_RUN   = 8'hD5;
    localparam logic [7:0] C_STALL = 8'h00;
    localparam logic [7:0] C_LDUSE = 8'h0D;
    localparam logic [7:0] C_BR    = 8'hAB;
    localparam logic [7:0] C_HALT  = 8'h01;

    logic             clk = 1'b0;
    logic             rst, ihit, dhit, mem_dreq, ex_dREN, br_taken, mem_halt;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic             exmem_en, exmem_flush, memwb_en, imem_ren, dmem_req_en, halted;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [7:0]       ctl;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_stall = '0;
    logic [CNT_W-1:0] exp_flush = '0;

    always #5 clk = ~clk;

    assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en};

    pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_ihit(ihit), .i_dhit(dhit), .i_mem_dreq(mem_dreq),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_ex_rd(ex_rd), .i_ex_dREN(ex_dREN),
        .i_br_taken(br_taken), .i_mem_halt(mem_halt),
        .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_ifid_flush(ifid_flush),
        .o_idex_en(idex_en), .o_idex_flush(idex_flush), .o_exmem_en(exmem_en),
        .o_exmem_flush(exmem_flush), .o_memwb_en(memwb_en), .o_imem_ren(imem_ren),
        .o_dmem_req_en(dmem_req_en), .o_halted(halted),
        .o_stall_cycles(stall_cycles), .o_flush_count(flush_count)
    );

    // Advance past the next rising edge, then let combinational outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1; ihit = 1; dhit = 0; mem_dreq = 0; ex_dREN = 0; br_taken = 0; mem_halt = 0;
        id_rs = 0; id_rt = 0; ex_rd = 0;
        #1;
        checks++;
        if ({ctl, imem_ren, dmem_req_en, halted} !== 11'b0) begin
            $display("FAIL reset_outputs act=%b exp=0", {ctl, imem_ren, dmem_req_en, halted}); errors++;
        end
        step();
        rst = 0;
        #1;
        checks++;
        if (ctl !== C_RUN) begin $display("FAIL reset_run_ctl act=%h exp=%h", ctl, C_RUN); errors++; end
        checks++;
        if ({imem_ren, dmem_req_en, halted} !== 3'b100) begin
            $display("FAIL reset_run_misc act=%b exp=100", {imem_ren, dmem_req_en, halted}); errors++;
        end
        checks++;
        if ({stall_cycles, flush_count} !== 8'h00) begin
            $display("FAIL reset_counters act=%h exp=00", {stall_cycles, flush_count}); errors++;
        end
        step();
    endtask

    task automatic test_mem_wait();
        mem_dreq = 1; dhit = 0; ihit = 1;
        #1;
        checks++;
        if ({ctl, imem_ren, dmem_req_en} !== {C_STALL, 2'b11}) begin
            $display("FAIL mem_wait_c0 act=%h_%b%b exp=00_11", ctl, imem_ren, dmem_req_en); errors++;
        end
        exp_stall = sat_inc(exp_stall);
        step();
        ihit = 0;
        for (int c = 1; c < 3; c++) begin
            #1;
            checks++;
            if ({ctl, imem_ren, dmem_req_en} !== {C_STALL, 2'b01}) begin
                $display("FAIL mem_wait_c%0d act=%h_%b%b exp=00_01", c, ctl, imem_ren, dmem_req_en); errors++;
            end
            exp_stall = sat_inc(exp_stall);
            step();
        end
        dhit = 1;
        #1;
        checks++;
        if (ctl !== C_RUN) begin $display("FAIL mem_wait_c3 act=%h exp=%h", ctl, C_RUN); errors++; end
        step();
        dhit = 0; mem_dreq = 0; ihit = 0;
        #1;
        checks++;
        if ({ctl, imem_ren} !== {C_STALL, 1'b1}) begin
            $display("FAIL mem_wait_seen_clr act=%h_%b exp=00_1", ctl, imem_ren); errors++;
        end
        exp_stall = sat_inc(exp_stall);
        step();
        ihit = 1;
        #1;
        step();
    endtask

    task automatic test_dhit_seen();
        mem_dreq = 1; dhit = 1; ihit = 0;
        #1;
        checks++;
        if ({ctl, dmem_req_en} !== {C_STALL, 1'b1}) begin
            $display("FAIL dseen_c0 act=%h_%b exp=00_1", ctl, dmem_req_en); errors++;
        end
        exp_stall = sat_inc(exp_stall);
        step();
        dhit = 0; ihit = 1;
        #1;
        checks++;
        if ({ctl, dmem_req_en} !== {C_RUN, 1'b0}) begin
            $display("FAIL dseen_c1 act=%h_%b exp=d5_0", ctl, dmem_req_en); errors++;
        end
        step();
        mem_dreq = 0;
    endtask

    task automatic test_load_use();
        logic [3*REG_W:0] vec [5];
        logic [7:0]       exp [5];
        vec[0] = {1'b1, 5'd5, 5'd3, 5'd5}; exp[0] = C_LDUSE;
        vec[1] = {1'b1, 5'd0, 5'd0, 5'd0}; exp[1] = C_RUN;
        vec[2] = {1'b1, 5'd7, 5'd7, 5'd2}; exp[2] = C_LDUSE;
        vec[3] = {1'b0, 5'd5, 5'd5, 5'd5}; exp[3] = C_RUN;
        vec[4] = {1'b1, 5'd5, 5'd6, 5'd4}; exp[4] = C_RUN;
        ihit = 1; mem_dreq = 0;
        for (int i = 0; i < 5; i++) begin
            {ex_dREN, ex_rd, id_rs, id_rt} = vec[i];
            #1;
            checks++;
            if (ctl !== exp[i]) begin
                $display("FAIL load_use_%0d act=%h exp=%h", i, ctl, exp[i]); errors++;
            end
            step();
        end
    endtask

    task automatic test_branch();
        ex_dREN = 1; ex_rd = 5; id_rs = 0; id_rt = 5; br_taken = 1;
        #1;
        checks++;
        if (ctl !== C_BR) begin $display("FAIL branch_over_lduse act=%h exp=%h", ctl, C_BR); errors++; end
        exp_flush = sat_inc(exp_flush);
        step();
        checks++;
        if (flush_count !== (PERF ? exp_flush : '0)) begin
            $display("FAIL flush_count_1 act=%0d exp=%0d", flush_count, PERF ? exp_flush : '0); errors++;
        end
        ex_dREN = 0;
        #1;
        checks++;
        if (ctl !== C_BR) begin $display("FAIL branch_plain act=%h exp=%h", ctl, C_BR); errors++; end
        exp_flush = sat_inc(exp_flush);
        step();
        br_taken = 0;
        #1;
        checks++;
        if ({stall_cycles, flush_count} !== (PERF ? {exp_stall, exp_flush} : 8'h00)) begin
            $display("FAIL counters act=%h exp=%h", {stall_cycles, flush_count},
                     PERF ? {exp_stall, exp_flush} : 8'h00); errors++;
        end
    endtask

    task automatic test_reset_mid_stall();
        mem_dreq = 1; dhit = 0; ihit = 1;
        step();
        rst = 1; ihit = 0;
        step();
        rst = 0; mem_dreq = 0;
        exp_stall = '0; exp_flush = '0;
        #1;
        checks++;
        if ({ctl, imem_ren} !== {C_STALL, 1'b1}) begin
            $display("FAIL rst_mid_stall act=%h_%b exp=00_1", ctl, imem_ren); errors++;
        end
        checks++;
        if ({stall_cycles, flush_count} !== 8'h00) begin
            $display("FAIL rst_mid_counters act=%h exp=00", {stall_cycles, flush_count}); errors++;
        end
    endtask

    task automatic test_saturation();
        ihit = 0; mem_dreq = 0;
        for (int c = 0; c < 20; c++) begin
            exp_stall = sat_inc(exp_stall);
            step();
        end
        checks++;
        if (stall_cycles !== (PERF ? 4'd15 : 4'd0)) begin
            $display("FAIL stall_sat act=%0d exp=%0d", stall_cycles, PERF ? 4'd15 : 4'd0); errors++;
        end
        ihit = 1;
        step();
    endtask

    task automatic test_halt();
        ihit = 1; mem_halt = 1; br_taken = 1;
        #1;
        checks++;
        if ({ctl, halted} !== {C_HALT, 1'b0}) begin
            $display("FAIL halt_entry act=%h_%b exp=01_0", ctl, halted); errors++;
        end
        step();
        mem_halt = 0; br_taken = 0; mem_dreq = 1; ihit = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({ctl, halted, imem_ren, dmem_req_en} !== {C_STALL, 3'b100}) begin
                $display("FAIL halt_hold_%0d act=%h_%b%b%b exp=00_100", c, ctl, halted, imem_ren, dmem_req_en);
                errors++;
            end
            step();
        end
        checks++;
        if (stall_cycles !== (PERF ? exp_stall : '0)) begin
            $display("FAIL halt_no_stall_cnt act=%0d exp=%0d", stall_cycles, PERF ? exp_stall : '0); errors++;
        end
        rst = 1;
        step();
        rst = 0; ihit = 1; mem_dreq = 0;
        #1;
        checks++;
        if ({ctl, halted} !== {C_RUN, 1'b0}) begin
            $display("FAIL halt_exit act=%h_%b exp=d5_0", ctl, halted); errors++;
        end
    endtask

    initial begin
        test_reset();
        test_mem_wait();
        test_dhit_seen();
        test_load_use();
        test_branch();
        test_reset_mid_stall();
        test_saturation();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
